// File: rtl/keys_pkg.sv
// Shared constants and helpers for the three-key debouncer.
// Imported by the per-key channel and the top level.
package keys_pkg;

   localparam int NUM_KEYS                = 3;
   localparam int DEFAULT_CLK_FREQ_HZ     = 80_000_000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_600_000;

   // Level a key reads when it is not being pressed.
   function automatic logic released_level(input bit key_active_low);
      return key_active_low ? 1'b1 : 1'b0;
   endfunction

endpackage : keys_pkg

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on each accepted released->pressed change.
module key_debounce_ch
   import keys_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic           RELEASED = released_level(KEY_ACTIVE_LOW);
   localparam logic [CNT_W-1:0] TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // s2 has disagreed with stable for DEBOUNCE_CYCLES samples in a row.
   assign accept = (s2 != stable) && (cnt == TERM);

   // NOTE: non-blocking assignments make s1->s2 a true two-stage shift;
   // blocking ones would collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= RELEASED;
         s2     <= RELEASED;
         stable <= RELEASED;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         s1    <= key;
         s2    <= s1;
         press <= accept && (s2 != RELEASED);
         if (s2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule : key_debounce_ch

// File: rtl/keys_debounce.sv
// Debounces three raw pushbuttons and emits a one-clock press pulse per key.
// Each key runs through an independent, identical key_debounce_ch.
module keys_debounce
   import keys_pkg::*;
#(
   parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
   parameter int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 50,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key0,
   input  logic key1,
   input  logic key2,
   output logic k0,
   output logic k1,
   output logic k2
);

   logic [NUM_KEYS-1:0] key_vec;
   logic [NUM_KEYS-1:0] press_vec;

   assign key_vec      = {key2, key1, key0};
   assign {k2, k1, k0} = press_vec;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .key   (key_vec[i]),
         .press (press_vec[i])
      );
   end

endmodule : keys_debounce

// File: tb/tb_keys_debounce.sv
// Directed bench for keys_debounce with DEBOUNCE_CYCLES = 16, active-low keys.
// Inputs change 1 ns after a rising edge; that edge is "edge 0" of a step.
module tb_keys_debounce;

   localparam int DC = 16;

   logic clk = 1'b0;
   logic rst;
   logic key0, key1, key2;
   logic k0, k1, k2;

   int checks = 0;
   int errors = 0;
   int p0 = 0, p1 = 0, p2 = 0;
   int b0, b1, b2;

   keys_debounce #(
      .CLK_FREQ_HZ     (80_000_000),
      .DEBOUNCE_CYCLES (DC),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .key0 (key0),
      .key1 (key1),
      .key2 (key2),
      .k0   (k0),
      .k1   (k1),
      .k2   (k2)
   );

   always #5 clk = ~clk;

   // Pulse tallies, sampled mid-cycle.
   always @(negedge clk) begin
      if (k0) p0++;
      if (k1) p1++;
      if (k2) p2++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      // 1. Reset with all keys released, then idle.
      rst = 1'b1; key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
      #2;
      check("rst_async_k", {29'd0, k2, k1, k0}, 0);
      step(3);
      check("rst_hold_k", {29'd0, k2, k1, k0}, 0);
      rst = 1'b0;
      step(100);
      check("idle_k", {29'd0, k2, k1, k0}, 0);
      check("idle_pulses", p0 + p1 + p2, 0);

      // 2. Clean press on key0: pulse after edge 2+DC only.
      b0 = p0;
      key0 = 1'b0;
      step(DC + 1);
      check("clean_k0_early", int'(k0), 0);
      step(1);
      check("clean_k0_pulse", int'(k0), 1);
      check("clean_k1_quiet", int'(k1), 0);
      check("clean_k2_quiet", int'(k2), 0);
      step(1);
      check("clean_k0_width", int'(k0), 0);
      step(100 - (DC + 3));
      check("clean_k0_held_once", p0 - b0, 1);
      key0 = 1'b1;
      step(40);
      check("release_no_pulse", p0 - b0, 1);

      // 3. Bouncing key1: no pulse while bouncing, one after settling.
      b1 = p1;
      for (int i = 0; i < 12; i++) begin
         key1 = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(5);
      end
      check("bounce_quiet", p1 - b1, 0);
      key1 = 1'b0;
      step(DC + 1);
      check("bounce_k1_early", int'(k1), 0);
      step(1);
      check("bounce_k1_pulse", int'(k1), 1);
      step(1);
      check("bounce_k1_width", int'(k1), 0);
      check("bounce_once", p1 - b1, 1);
      key1 = 1'b1;
      step(25);

      // 4. Glitch rejection on key2: DC-1 samples rejected, DC accepted.
      b2 = p2;
      key2 = 1'b0;
      step(DC - 1);
      key2 = 1'b1;
      step(30);
      check("glitch_rejected", p2 - b2, 0);
      key2 = 1'b0;
      step(DC);
      key2 = 1'b1;
      step(1);
      check("exact_k2_early", int'(k2), 0);
      step(1);
      check("exact_k2_pulse", int'(k2), 1);
      step(20);
      check("exact_once", p2 - b2, 1);

      // 5. Simultaneous key0 + key2.
      b0 = p0; b1 = p1; b2 = p2;
      key0 = 1'b0; key2 = 1'b0;
      step(DC + 2);
      check("sim_k0", int'(k0), 1);
      check("sim_k2", int'(k2), 1);
      check("sim_k1", int'(k1), 0);
      step(1);
      check("sim_after", {29'd0, k2, k1, k0}, 0);
      key0 = 1'b1; key2 = 1'b1;
      step(25);
      check("sim_counts", (p0 - b0) * 100 + (p1 - b1) * 10 + (p2 - b2), 101);

      // 6. Reset mid-count with key0 held, then fresh debounce.
      b0 = p0;
      key0 = 1'b0;
      step(12);
      rst = 1'b1;
      #1;
      check("midrst_k0_async", int'(k0), 0);
      step(DC + 4);
      check("midrst_no_pulse", p0 - b0, 0);
      rst = 1'b0;
      step(DC + 1);
      check("midrst_k0_early", int'(k0), 0);
      step(1);
      check("midrst_k0_pulse", int'(k0), 1);
      step(1);
      check("midrst_k0_width", int'(k0), 0);
      step(30);
      check("midrst_once", p0 - b0, 1);
      key0 = 1'b1;
      step(25);
      check("final_quiet", {29'd0, k2, k1, k0}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_keys_debounce

// File: doc/keys_debounce.md
Name: keys_debounce

Overview:
Debounces three raw pushbutton inputs (key0..key2) and emits a one-clock press pulse (k0..k2) per debounced press. Runs in the 80 MHz system domain. Pulses feed control logic as toggle/restart events, e.g. mode toggle and cycle-counter restart in the tag controller.

Parameters:
CLK_FREQ_HZ, 80_000_000, system clock frequency; documentation only, used to derive the default below.
DEBOUNCE_CYCLES, 1_600_000, number of consecutive stable cycles required to accept a level change (20 ms at 80 MHz); must be ≥2; benches override it to a small value.
KEY_ACTIVE_LOW, 1, 1 = a pressed key reads 0 on keyN; 0 = a pressed key reads 1.

Ports:
clk  input  1  system clock (80 MHz); all state on rising edge
rst  input  1  asynchronous, active-high reset
key0  input  1  raw, asynchronous, bouncing button 0
key1  input  1  raw, asynchronous, bouncing button 1
key2  input  1  raw, asynchronous, bouncing button 2
k0  output  1  one-cycle pulse on debounced press of key0
k1  output  1  one-cycle pulse on debounced press of key1
k2  output  1  one-cycle pulse on debounced press of key2

Behaviour:
- Reset is asynchronous and active-high. Only one clock and one reset exist.
- Per-key channel; the three channels are fully independent and identical.
- Synchronizer: 2-flop chain s1 -> s2. Both flops reset to the released level (1 if KEY_ACTIVE_LOW, else 0).
- stable register: reset to released. Counter: width ceil(log2(DEBOUNCE_CYCLES)), reset to 0.
- Each edge where s2 == stable: counter <= 0.
- Each edge where s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
- Each edge where s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2 and counter <= 0.
- Any bounce back to the stable level before the terminal count clears the counter. The required level must hold for exactly DEBOUNCE_CYCLES consecutive s2 samples.
- kN is registered and reset to 0. kN <= 1 only on the edge where stable changes released->pressed; otherwise kN <= 0. Pulse width is exactly 1 cycle.
- No pulse on release; a held key yields exactly one pulse.
- Latency: key held pressed and first sampled at edge 1 -> s2 pressed after edge 2 -> stable flips and kN goes high after edge 2+DEBOUNCE_CYCLES -> kN low after edge 3+DEBOUNCE_CYCLES.
- Simultaneous presses on several keys produce pulses in the same cycle.
- Reset mid-operation: all state returns to released/0 immediately, and no pulse is emitted while rst is high. A key still held after rst deasserts is debounced afresh and produces one pulse after 2+DEBOUNCE_CYCLES edges.
- Counter never wraps; it saturates via the terminal-count rule above.

Decomposition:
- Shared package keys_pkg: NUM_KEYS = 3, default DEBOUNCE_CYCLES, and a function returning the released level from KEY_ACTIVE_LOW.
- One sub-module, key_debounce_ch (sync + counter + stable + pulse for one key), instantiated three times by keys_debounce.

Test Plan (DEBOUNCE_CYCLES = 16, KEY_ACTIVE_LOW = 1):
1. Reset: assert rst with keys = 1 -> k0/k1/k2 = 0 during and after reset, with no spurious pulse over 100 cycles.
2. Clean press: drive key0 = 0 at edge 0 and hold -> k0 = 1 for exactly one cycle after edge 18, k0 = 0 thereafter; k1 = k2 = 0. Release after 100 cycles -> no pulse.
3. Bounce: key1 toggles 0/1 every 5 cycles for 60 cycles, then holds 0 -> k1 stays 0 during bouncing; exactly one pulse 18 edges after the final settle.
4. Glitch rejection: key2 = 0 for 15 cycles, then 1 -> k2 never asserts. key2 = 0 for 16 cycles (as s2 samples) -> one pulse.
5. Simultaneous: key0 and key2 pressed on the same edge -> k0 and k2 pulse in the same cycle; k1 = 0.
6. Reset mid-press: key0 held 0, rst pulsed at cycle 10 of the count -> no pulse during the count. After rst falls, exactly one k0 pulse 18 edges later.
